// File: rtl/apb_requester.sv
// APB5 requester: buffers valid/ready commands in a small FIFO and
// replays them as SETUP/ACCESS transfers with an optional PREADY timeout.
module apb_requester #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CMD_DEPTH  = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic [2:0]              pprot,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pslverr
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int PW = $clog2(CMD_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLIM =
    TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  typedef struct packed {
    logic                  write;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [SW-1:0]         strb;
    logic [2:0]            prot;
  } cmd_t;

  cmd_t            fifo [CMD_DEPTH];
  cmd_t            cmd_in;
  cmd_t            head;
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   count;
  logic [1:0]      state;
  logic [TW-1:0]   tcnt;
  logic            push;
  logic            pop;
  logic            done;
  logic            abort;
  logic [DATA_WIDTH-1:0] nxt_wdata;
  logic [SW-1:0]   nxt_strb;

  assign cmd_in = {cmd_write, cmd_addr, cmd_wdata,
                   cmd_strb, cmd_prot};
  assign head = fifo[rptr];

  assign cmd_ready = (count != CW'(CMD_DEPTH));
  assign push = cmd_valid && cmd_ready;
  assign done = (state == S_ACCESS) && pready;
  assign abort = (state == S_ACCESS) && !pready &&
                 (TIMEOUT != 0) && (tcnt == TLIM);
  assign pop = (count != '0) &&
               ((state == S_IDLE) || done);
  assign busy = (state != S_IDLE) || (count != '0);

  // Reads never drive write data or strobes onto the bus
  assign nxt_wdata = head.write ? head.wdata : '0;
  assign nxt_strb  = head.write ? head.strb  : '0;

  always_ff @(posedge pclk) begin
    if (push && !preset) begin
      fifo[wptr] <= cmd_in;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= S_IDLE;
      tcnt        <= '0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pprot       <= '0;
      pwdata      <= '0;
      pstrb       <= '0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (1'b1)
        (state == S_IDLE): begin
          if (pop) begin
            state   <= S_SETUP;
            psel    <= 1'b1;
            penable <= 1'b0;
            pwrite  <= head.write;
            paddr   <= head.addr;
            pprot   <= head.prot;
            pwdata  <= nxt_wdata;
            pstrb   <= nxt_strb;
          end
        end
        (state == S_SETUP): begin
          state   <= S_ACCESS;
          penable <= 1'b1;
          tcnt    <= '0;
        end
        (state == S_ACCESS): begin
          if (done) begin
            rsp_valid   <= 1'b1;
            rsp_write   <= pwrite;
            rsp_rdata   <= pwrite ? '0 : prdata;
            rsp_err     <= pslverr;
            rsp_timeout <= 1'b0;
            if (pop) begin
              state   <= S_SETUP;
              penable <= 1'b0;
              pwrite  <= head.write;
              paddr   <= head.addr;
              pprot   <= head.prot;
              pwdata  <= nxt_wdata;
              pstrb   <= nxt_strb;
            end else begin
              state   <= S_IDLE;
              psel    <= 1'b0;
              penable <= 1'b0;
              pwrite  <= 1'b0;
              paddr   <= '0;
              pprot   <= '0;
              pwdata  <= '0;
              pstrb   <= '0;
            end
          end else if (abort) begin
            rsp_valid   <= 1'b1;
            rsp_write   <= pwrite;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            state       <= S_IDLE;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pprot       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
          end else if (TIMEOUT != 0) begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: begin
          state   <= S_IDLE;
          psel    <= 1'b0;
          penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_requester.sv
// Scoreboard bench for apb_requester: random commands, a behavioural
// completer, and an in-order expected-response queue.
module tb_apb_requester;

  localparam int TO = 16;

  logic        pclk = 1'b0;
  logic        preset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        busy;
  logic [31:0] paddr;
  logic [2:0]  pprot;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;

  apb_requester #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32),
    .CMD_DEPTH(4), .TIMEOUT(TO)
  ) dut (
    .pclk(pclk), .preset(preset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .busy(busy),
    .paddr(paddr), .pprot(pprot), .psel(psel),
    .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .pstrb(pstrb),
    .pready(pready), .prdata(prdata),
    .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    bit write; bit [31:0] addr; int waits; bit err;
    bit [31:0] wdata; bit [3:0] strb;
  } plan_t;
  typedef struct {
    bit write; bit [31:0] rdata; bit err; bit tmo; int acc;
  } rsp_t;
  typedef struct {
    bit write; bit [31:0] addr; bit [31:0] wdata;
    bit [3:0] strb; bit [2:0] prot;
  } xfer_t;

  plan_t plan_q[$];
  rsp_t  rsp_q[$];
  xfer_t xfer_q[$];
  bit [31:0] ref_mem [bit [31:0]];
  bit [31:0] slv_mem [bit [31:0]];

  int checks = 0;
  int failures = 0;
  int rises = 0;
  int setups = 0;
  bit saw_full = 0;

  function automatic void chk(string name, logic [63:0] act,
                              logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  function automatic bit [31:0] merge(bit [31:0] old,
                                      bit [31:0] wd, bit [3:0] s);
    bit [31:0] r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  // Behavioural completer: pready after plan.waits low ACCESS cycles
  plan_t pc;
  int    k;
  always @(negedge pclk) begin
    if (psel && !penable) begin
      if (plan_q.size() != 0) pc = plan_q.pop_front();
      k = 0;
      pready = 1'b0;
    end else if (psel && penable) begin
      if (k == pc.waits) begin
        pready  = 1'b1;
        pslverr = pc.err;
        if (pc.write) begin
          prdata = $urandom;
          if (!pc.err)
            slv_mem[pc.addr] = merge(slv_mem.exists(pc.addr) ?
              slv_mem[pc.addr] : 32'h0, pc.wdata, pc.strb);
        end else begin
          prdata = slv_mem.exists(pc.addr) ? slv_mem[pc.addr] : 32'h0;
        end
      end else begin
        pready  = 1'b0;
        pslverr = 1'($urandom_range(0, 1));
        prdata  = $urandom;
      end
      k++;
    end else begin
      pready = 1'b0;
    end
  end

  // Monitor: response scoreboard plus APB phase checks
  rsp_t  e;
  xfer_t cx;
  int    acc = 0;
  bit    prev_psel = 0;
  always @(negedge pclk) begin
    if (!preset) begin
      if (rsp_valid) begin
        if (rsp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_rsp actual=1 required=0");
        end else begin
          e = rsp_q.pop_front();
          chk("rsp_write", rsp_write, e.write);
          chk("rsp_err", rsp_err, e.err);
          chk("rsp_timeout", rsp_timeout, e.tmo);
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("access_cycles", acc, e.acc);
          if (e.tmo) chk("tmo_psel_low", psel, 0);
        end
      end
      if (psel && !penable) begin
        if (xfer_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_setup actual=1 required=0");
        end else begin
          cx = xfer_q.pop_front();
          chk("setup_addr", paddr, cx.addr);
          chk("setup_ctl", {pwrite, pstrb, pprot, pwdata},
              {cx.write, cx.strb, cx.prot, cx.wdata});
        end
        acc = 0;
        setups++;
      end
      if (psel && penable) begin
        acc++;
        chk("hold_addr", paddr, cx.addr);
        chk("hold_ctl", {pwrite, pstrb, pprot, pwdata},
            {cx.write, cx.strb, cx.prot, cx.wdata});
      end
      if (psel && !prev_psel) rises++;
      if (!cmd_ready) saw_full = 1;
      prev_psel = psel;
    end
  end

  task automatic push(bit w, bit [31:0] a, bit [31:0] wd,
                      bit [3:0] s, bit [2:0] p, int waits, bit err);
    plan_t pl; rsp_t r; xfer_t x; bit [31:0] cur; bit tmo; int n;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a;
    cmd_wdata = wd; cmd_strb = s; cmd_prot = p;
    n = 0;
    while (!cmd_ready && n < 2000) begin
      @(negedge pclk); n++;
    end
    if (!cmd_ready) begin
      checks++; failures++;
      $display("FAIL cmd_ready_wait actual=0 required=1");
      cmd_valid = 1'b0;
      return;
    end
    tmo = (waits >= TO);
    cur = ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    r.write = w; r.tmo = tmo; r.err = tmo || err;
    r.acc = tmo ? TO : waits + 1;
    r.rdata = (w || tmo) ? 32'h0 : cur;
    if (w && !tmo && !err) ref_mem[a] = merge(cur, wd, s);
    x.write = w; x.addr = a; x.prot = p;
    x.wdata = w ? wd : 32'h0; x.strb = w ? s : 4'h0;
    pl.write = w; pl.addr = a; pl.waits = waits; pl.err = err;
    pl.wdata = wd; pl.strb = s;
    plan_q.push_back(pl); rsp_q.push_back(r); xfer_q.push_back(x);
    @(posedge pclk);
    @(negedge pclk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || rsp_q.size() != 0) && n < 4000) begin
      @(negedge pclk); n++;
    end
    repeat (2) @(negedge pclk);
    chk("drain_pending", rsp_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    preset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0;
    pready = 1'b0; prdata = '0; pslverr = 1'b0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    chk("rst_psel_en", {psel, penable}, 0);
    chk("rst_apb", {pwrite, paddr, pprot, pwdata, pstrb}, 0);
    chk("rst_rsp", {rsp_valid, rsp_write, rsp_err, rsp_timeout}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    preset = 1'b0;
    @(negedge pclk);

    push(1, 32'h84, 32'h12345678, 4'hF, 3'b010, 0, 0);
    wait_idle();
    push(0, 32'h84, 32'hDEADBEEF, 4'hF, 3'b000, 0, 0);
    wait_idle();
    push(0, 32'h84, 32'h0, 4'h3, 3'b001, 3, 1);
    wait_idle();
    push(1, 32'h88, 32'hCAFEF00D, 4'h5, 3'b111, 255, 0);
    wait_idle();
    push(0, 32'h88, 32'h0, 4'h0, 3'b000, 15, 0);
    wait_idle();
    push(0, 32'h84, 32'h0, 4'h0, 3'b000, 16, 0);
    wait_idle();

    rises = 0; setups = 0; saw_full = 0;
    push(1, 32'h0, 32'h11111111, 4'hF, 3'b000, 6, 0);
    push(1, 32'h4, 32'h22222222, 4'hF, 3'b000, 0, 0);
    push(1, 32'h8, 32'h33333333, 4'hF, 3'b000, 0, 0);
    push(1, 32'hC, 32'h44444444, 4'hF, 3'b000, 0, 0);
    push(1, 32'h10, 32'h55555555, 4'hF, 3'b000, 0, 0);
    chk("full_ready_low", cmd_ready, 0);
    wait_idle();
    chk("b2b_psel_rises", rises, 1);
    chk("b2b_setups", setups, 5);
    chk("b2b_saw_full", saw_full, 1);

    push(0, 32'h4, 32'h0, 4'h0, 3'b000, 255, 0);
    push(0, 32'h8, 32'h0, 4'h0, 3'b000, 0, 0);
    push(0, 32'hC, 32'h0, 4'h0, 3'b000, 0, 0);
    repeat (3) @(negedge pclk);
    chk("pre_rst_access", {psel, penable}, 2'b11);
    preset = 1'b1;
    @(posedge pclk);
    plan_q.delete(); rsp_q.delete(); xfer_q.delete();
    @(negedge pclk);
    chk("mid_rst_psel_en", {psel, penable}, 0);
    chk("mid_rst_rsp", rsp_valid, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    chk("mid_rst_busy", busy, 0);
    preset = 1'b0;
    repeat (20) @(negedge pclk);
    chk("post_rst_idle", {psel, busy}, 0);

    for (int i = 0; i < 200; i++) begin
      int r; int w;
      r = $urandom_range(0, 19);
      w = (r < 12) ? 0 :
          (r < 18) ? $urandom_range(1, 4) : $urandom_range(14, 17);
      push(1'($urandom_range(0, 1)),
           32'($urandom_range(0, 15) * 4), $urandom,
           4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
           w, ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) @(negedge pclk);
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_requester.md
Name: apb_requester

Overview:
- Synthesizable APB5 requester (manager) engine that replaces task-based bench driving with a reusable RTL front end.
- Accepts read/write commands through a valid/ready command port and buffers them in a CMD_DEPTH-entry FIFO.
- Executes each command as an APB SETUP/ACCESS transfer, with back-to-back transfers and a programmable PREADY timeout.
- Reports each completion on a single-cycle response port.
- Sits between a test sequencer or CPU-side fabric and any APB completer on the shared APB interface.

Parameters:
- DATA_WIDTH, 32, PWDATA/PRDATA width; multiple of 8, range 8..64.
- ADDR_WIDTH, 32, PADDR width.
- CMD_DEPTH, 4, command FIFO entries; power of 2, at least 2.
- TIMEOUT, 16, maximum ACCESS wait cycles with PREADY low before abort; 0 disables the timeout.

Ports:
- pclk  in  1  APB clock; all logic is on its rising edge.
- preset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  DATA_WIDTH/8  write byte strobes.
- cmd_prot  in  3  PPROT value.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_write  out  1  direction of the completed command.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR was sampled high, or a timeout occurred.
- rsp_timeout  out  1  transfer was aborted by the timeout.
- busy  out  1  FSM not IDLE or FIFO non-empty.
- paddr  out  ADDR_WIDTH  APB address.
- pprot  out  3  APB protection.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  DATA_WIDTH/8  APB write strobes.
- pready  in  1  completer ready.
- prdata  in  DATA_WIDTH  completer read data.
- pslverr  in  1  completer error.

Behaviour:
- Clock and reset:
  - One clock, pclk; preset is synchronous and active-high.
  - All APB and response outputs are registered.
- Reset values:
  - psel, penable, pwrite, paddr, pprot, pwdata, pstrb = 0.
  - rsp_* = 0; busy = 0; cmd_ready = 1.
  - FIFO empty; FSM in IDLE; timeout counter = 0.
- Command FIFO:
  - A push occurs on any edge where cmd_valid and cmd_ready are both high.
  - cmd_ready = (count != CMD_DEPTH); it does not depend on a same-cycle pop.
  - A simultaneous push and pop on a non-full FIFO leaves count unchanged.
  - Pointers wrap modulo CMD_DEPTH.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - psel = penable = 0; paddr, pwdata, pstrb, pwrite = 0.
  - On FIFO non-empty, pop the head and go to SETUP.
  - Latency: a command pushed at edge E0 into an empty FIFO raises psel after edge E1 and penable after edge E2.
- SETUP (exactly one cycle):
  - psel = 1, penable = 0.
  - paddr, pprot and pwrite come from the command.
  - Writes: pwdata = cmd_wdata, pstrb = cmd_strb.
  - Reads: pwdata = 0, pstrb = 0 (APB5 rule).
  - Next state is ACCESS, and the timeout counter clears.
- ACCESS:
  - psel = penable = 1; all other APB outputs held stable.
  - Completion is the edge where pready = 1.
    - On that edge, register rsp_valid = 1, rsp_write, rsp_err = pslverr, rsp_timeout = 0.
    - rsp_rdata = prdata for reads, 0 for writes.
    - If the FIFO is non-empty, pop and go straight to SETUP: psel stays 1, penable drops to 0, and the next address is presented.
    - Otherwise go to IDLE.
  - While pready = 0 and TIMEOUT != 0, the counter increments each cycle.
    - When the counter reaches TIMEOUT with pready still low, abort.
    - Abort emits a response with rsp_err = 1, rsp_timeout = 1, rsp_rdata = 0, then goes to IDLE with psel = penable = 0.
    - A pready that arrives in the same cycle as the limit wins: normal completion.
- pslverr and prdata are sampled only at completion.
- The response port has no backpressure. rsp_valid is high for exactly one cycle per command, and response fields hold their last value when rsp_valid = 0.
- Responses are issued strictly in command order.
- Reset mid-transfer:
  - psel and penable drop on the reset edge, and the FIFO is flushed.
  - No response is emitted for in-flight or queued commands.
- busy = (state != IDLE) || (count != 0).

Test Plan:
- Single write:
  - Push write addr 0x84, data 0x12345678, strb 0xF, prot 3'b010; completer pready = 1 immediately.
  - Expect: SETUP with psel = 1, penable = 0; ACCESS with penable = 1.
  - Expect: rsp_valid pulse with rsp_err = 0, rsp_write = 1; pstrb = 0xF.
- Readback:
  - Push read 0x84, prot 0.
  - Expect: pstrb = 0, pwdata = 0 during the transfer.
  - Expect: rsp_rdata = 0x12345678, rsp_err = 0.
- Wait states and error:
  - Completer holds pready = 0 for 3 cycles, then raises pready with pslverr = 1.
  - Expect: penable high for 4 cycles, APB outputs stable throughout.
  - Expect: rsp_err = 1, rsp_timeout = 0.
- Timeout:
  - TIMEOUT = 16 with pready tied low.
  - Expect: abort after 16 ACCESS wait cycles; rsp_timeout = 1, rsp_err = 1, rsp_rdata = 0; psel low next cycle.
- Back-to-back and full FIFO:
  - Push 5 writes (addr 0x0, 0x4, 0x8, 0xC, 0x10) continuously with pready = 1.
  - Expect: cmd_ready drops when 4 entries are queued.
  - Expect: psel never deasserts between transfers; each transfer is SETUP then ACCESS (2 cycles).
  - Expect: 5 responses in order.
- Reset mid-ACCESS:
  - Assert preset during a waited ACCESS with 2 commands queued.
  - Expect: psel = penable = 0 after the reset edge, no rsp_valid, cmd_ready = 1, busy = 0.
